// File: rtl/motor_arb_pkg.sv
// Shared types and constants for the motor H-bridge arbiter.
// The STALL state exists only when MOTOR_ARB_STALL_EN is defined.
package motor_arb_pkg;

  localparam int PWM_W_DEF     = 8;
  localparam int DEAD_CYC_DEF  = 16;
  localparam int STALL_CYC_DEF = 1024;

  localparam int REQ_STALL  = 0;
  localparam int REQ_AVOID  = 1;
  localparam int REQ_CORNER = 2;
  localparam int REQ_SEARCH = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DEAD  = 2'd2
`ifdef MOTOR_ARB_STALL_EN
    ,
    ST_STALL = 2'd3
`endif
  } state_e;

  // Lowest set index wins; the result is only meaningful when r != 0.
  function automatic logic [1:0] pri_idx(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/motor_arbiter_pwm_gen.sv
// Free-running PWM counter with one duty comparator per H-bridge side.
module pwm_gen #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [PWM_W-1:0] i_duty_l,
  input  logic [PWM_W-1:0] i_duty_r,
  output logic             o_pwm_l,
  output logic             o_pwm_r
);

  logic [PWM_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= r_cnt + 1'b1;
  end

  assign o_pwm_l = i_en && (r_cnt < i_duty_l);
  assign o_pwm_r = i_en && (r_cnt < i_duty_r);

endmodule

// File: rtl/motor_arbiter.sv
// Four-requester priority arbiter for a dual H-bridge with dead-time insertion.
// Optional overcurrent stall detection is enabled by defining MOTOR_ARB_STALL_EN.
module motor_arbiter
  import motor_arb_pkg::*;
#(
  parameter int PWM_W     = PWM_W_DEF,
  parameter int DEAD_CYC  = DEAD_CYC_DEF,
  parameter int STALL_CYC = STALL_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [7:0]         cmd_dir,
  input  logic [4*PWM_W-1:0] cmd_duty,
  input  logic [1:0]         sense,
  output logic [3:0]         grant,
  output logic               pwm_l,
  output logic               pwm_r,
  output logic               dir_l,
  output logic               dir_r,
  output logic               stalled
);

  localparam int DW = $clog2(DEAD_CYC + 1);

  state_e           r_state;
  logic [3:0]       r_grant;
  logic [1:0]       r_gidx;
  logic [1:0]       r_dir;
  logic [DW-1:0]    r_dead_cnt;

  logic [PWM_W-1:0] w_duty;
  logic             w_preempt;
  logic             w_dir_chg;
  logic             w_hold;
  logic             w_any;
  logic             w_dead_done;
  logic [1:0]       w_new_idx;
  logic [1:0]       w_new_dir;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    w_duty    = '0;
    w_preempt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) == r_gidx) w_duty = cmd_duty[PWM_W*i +: PWM_W];
      if (2'(i) < r_gidx && req[i]) w_preempt = 1'b1;
    end
  end

  assign w_any       = |req;
  assign w_hold      = req[r_gidx];
  assign w_new_idx   = pri_idx(req);
  assign w_new_dir   = cmd_dir[{w_new_idx, 1'b0} +: 2];
  assign w_dir_chg   = cmd_dir[{r_gidx, 1'b0} +: 2] != r_dir;
  assign w_dead_done = r_dead_cnt == DW'(DEAD_CYC - 1);

`ifdef MOTOR_ARB_STALL_EN
  localparam int SW = $clog2(STALL_CYC + 1);

  logic [SW-1:0] r_stall_cnt;
  logic          r_stalled;
  logic          w_stall_hit;
  logic          w_stall_trip;

  // Both sides share one duty, so any asserted sense bit qualifies.
  assign w_stall_hit  = (r_state == ST_DRIVE) && (sense != 2'b00) && (w_duty != '0);
  assign w_stall_trip = w_stall_hit && (r_stall_cnt == SW'(STALL_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_stall_cnt <= '0;
    else if (w_stall_hit && !w_stall_trip) r_stall_cnt <= r_stall_cnt + 1'b1;
    else                                 r_stall_cnt <= '0;
  end

  assign stalled = r_stalled;
`else
  logic w_unused_sense;
  assign w_unused_sense = ^sense;
  assign stalled        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_gidx     <= '0;
      r_dir      <= '0;
      r_dead_cnt <= '0;
`ifdef MOTOR_ARB_STALL_EN
      r_stalled  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_DRIVE;
            r_grant <= 4'(1) << w_new_idx;
            r_gidx  <= w_new_idx;
            r_dir   <= w_new_dir;
          end
        end
        ST_DRIVE: begin
`ifdef MOTOR_ARB_STALL_EN
          if (w_stall_trip) begin
            r_state   <= ST_STALL;
            r_grant   <= '0;
            r_stalled <= 1'b1;
          end else
`endif
          // Preemption and direction change win over a simultaneous holder drop.
          if (w_preempt || w_dir_chg) begin
            r_state    <= ST_DEAD;
            r_grant    <= '0;
            r_dead_cnt <= '0;
          end else if (!w_hold) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
          end
        end
        ST_DEAD: begin
          if (w_dead_done) begin
            r_dead_cnt <= '0;
            if (w_any) begin
              r_state <= ST_DRIVE;
              r_grant <= 4'(1) << w_new_idx;
              r_gidx  <= w_new_idx;
              r_dir   <= w_new_dir;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_dead_cnt <= r_dead_cnt + 1'b1;
          end
        end
`ifdef MOTOR_ARB_STALL_EN
        ST_STALL: begin
          if (sense == 2'b00) begin
            if (req[REQ_STALL]) begin
              r_state    <= ST_DEAD;
              r_dead_cnt <= '0;
              r_stalled  <= 1'b0;
            end else if (!w_any) begin
              r_state   <= ST_IDLE;
              r_stalled <= 1'b0;
            end
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  pwm_gen #(.PWM_W(PWM_W)) u_pwm_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (r_state == ST_DRIVE),
    .i_duty_l (w_duty),
    .i_duty_r (w_duty),
    .o_pwm_l  (pwm_l),
    .o_pwm_r  (pwm_r)
  );

  assign grant = r_grant;
  assign dir_l = r_dir[0];
  assign dir_r = r_dir[1];

endmodule

// File: tb/tb_motor_arbiter.sv
// Self-checking bench for motor_arbiter: a cycle model plus directed scenarios.
// The stall scenario runs only when MOTOR_ARB_STALL_EN is defined.
module tb_motor_arbiter;

`ifdef MOTOR_ARB_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [7:0]  cmd_dir = '0;
  logic [31:0] cmd_duty = '0;
  logic [1:0]  sense = '0;
  logic [3:0]  grant;
  logic        pwm_l, pwm_r, dir_l, dir_r, stalled;

  int n_checks = 0;
  int n_pass   = 0;

  motor_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .cmd_dir  (cmd_dir),
    .cmd_duty (cmd_duty),
    .sense    (sense),
    .grant    (grant),
    .pwm_l    (pwm_l),
    .pwm_r    (pwm_r),
    .dir_l    (dir_l),
    .dir_r    (dir_r),
    .stalled  (stalled)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: owner (-1 = nobody driving), remaining dead clocks, stall flag.
  int       m_owner = -1;
  int       m_dead  = 0;
  int       m_run   = 0;
  int       m_cnt   = 0;
  bit       m_stalled = 1'b0;
  bit [1:0] m_dir   = 2'b00;

  function automatic int duty_of(input int o);
    return int'(cmd_duty[8*o +: 8]);
  endfunction

  function automatic int pick(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic m_arbitrate();
    m_owner = pick(req);
    if (m_owner >= 0) m_dir = cmd_dir[2*m_owner +: 2];
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_dead = 0; m_run = 0; m_cnt = 0; m_stalled = 1'b0; m_dir = 2'b00;
    end else begin
      m_cnt = (m_cnt + 1) % 256;
      if (m_stalled) begin
        m_run = 0;
        if (sense == 2'b00 && req[0]) begin m_stalled = 1'b0; m_dead = 16; end
        else if (sense == 2'b00 && req == 4'b0000) m_stalled = 1'b0;
      end else if (m_dead > 0) begin
        m_run = 0;
        m_dead--;
        if (m_dead == 0) m_arbitrate();
      end else if (m_owner < 0) begin
        m_run = 0;
        m_arbitrate();
      end else begin
        int  o;
        bit  higher;
        o = m_owner;
        m_run = (sense != 2'b00 && duty_of(o) != 0) ? m_run + 1 : 0;
        higher = 1'b0;
        for (int i = 0; i < o; i++) if (req[i]) higher = 1'b1;
        if (STALL_EN && m_run >= 1024) begin
          m_owner = -1; m_stalled = 1'b1; m_run = 0;
        end else if (higher || cmd_dir[2*o +: 2] != m_dir) begin
          m_owner = -1; m_dead = 16;
        end else if (!req[o]) begin
          m_owner = -1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] e_grant;
    logic       e_pwm;
    e_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    e_pwm   = (m_owner >= 0) && (m_cnt < duty_of(m_owner));
    check("model_grant",   32'(grant),   32'(e_grant));
    check("model_pwm_l",   32'(pwm_l),   32'(e_pwm));
    check("model_pwm_r",   32'(pwm_r),   32'(e_pwm));
    check("model_dir",     32'({dir_r, dir_l}), 32'(m_dir));
    check("model_stalled", 32'(stalled), 32'(m_stalled));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic count_pwm(output int n);
    n = 0;
    repeat (256) begin
      @(negedge clk);
      if (pwm_l) n++;
    end
  endtask

  // Counts observed cycles with grant low after the next edge, bounded.
  task automatic count_dead(output int n);
    @(posedge clk);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (grant != 4'b0000) break;
      if (pwm_l || pwm_r) check("dead_pwm_low", 32'({pwm_r, pwm_l}), 32'd0);
      n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;

    repeat (3) @(negedge clk);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_outs",  32'({pwm_l, pwm_r, dir_l, dir_r, stalled}), 32'd0);
    tick();
    rst_n = 1'b1;

    // Search requester alone: grant next clock, 64/256 duty, dir 11.
    tick();
    cmd_dir[7:6]    = 2'b11;
    cmd_duty[31:24] = 8'd64;
    req             = 4'b1000;
    @(posedge clk); @(negedge clk);
    check("s1_grant", 32'(grant), 32'h8);
    count_pwm(n);
    check("s1_pwm_64", 32'(n), 32'd64);
    check("s1_dir", 32'({dir_r, dir_l}), 32'h3);

    // Avoid preempts search: 16 dead clocks then grant avoid.
    tick();
    cmd_dir[3:2]    = 2'b11;
    cmd_duty[15:8]  = 8'd100;
    req             = 4'b1010;
    count_dead(n);
    check("preempt_dead_len", 32'(n), 32'd16);
    check("preempt_grant", 32'(grant), 32'h2);

    // Holder flips direction 11 -> 01.
    tick();
    cmd_dir[3:2] = 2'b01;
    count_dead(n);
    check("dirflip_dead_len", 32'(n), 32'd16);
    check("dirflip_grant", 32'(grant), 32'h2);
    check("dirflip_dir_l", 32'(dir_l), 32'd1);
    check("dirflip_dir_r", 32'(dir_r), 32'd0);

    // Duty boundaries on the live holder.
    tick();
    cmd_duty[15:8] = 8'd0;
    count_pwm(n);
    check("duty0_pwm", 32'(n), 32'd0);
    tick();
    cmd_duty[15:8] = 8'hFF;
    count_pwm(n);
    check("dutyff_pwm", 32'(n), 32'd255);

    // All requests drop: IDLE next clock.
    tick();
    req = 4'b0000;
    @(posedge clk); @(negedge clk);
    check("drop_grant", 32'(grant), 32'd0);
    check("drop_pwm", 32'({pwm_l, pwm_r}), 32'd0);

`ifdef MOTOR_ARB_STALL_EN
    tick();
    cmd_dir[5:4]    = 2'b10;
    cmd_duty[23:16] = 8'd128;
    req             = 4'b0100;
    @(posedge clk); @(negedge clk);
    check("stall_pre_grant", 32'(grant), 32'h4);
    tick();
    sense = 2'b01;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!stalled && n < 3000);
    check("stall_latency", 32'(n), 32'd1024);
    check("stall_grant", 32'(grant), 32'd0);
    check("stall_pwm", 32'({pwm_l, pwm_r}), 32'd0);
    tick();
    sense = 2'b00;
    req   = 4'b0001;
    count_dead(n);
    check("stall_exit_dead_len", 32'(n), 32'd16);
    check("stall_exit_grant", 32'(grant), 32'h1);
    check("stall_exit_flag", 32'(stalled), 32'd0);
    tick();
    req = 4'b0000;
    repeat (3) @(posedge clk);
`endif

    // Reset asserted mid-DEAD clears outputs at once.
    tick();
    req = 4'b1000;
    @(posedge clk); @(negedge clk);
    check("rst_pre_grant", 32'(grant), 32'h8);
    tick();
    req = 4'b1010;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async_grant", 32'(grant), 32'd0);
    check("rst_async_outs", 32'({pwm_l, pwm_r, dir_l, dir_r, stalled}), 32'd0);
    cmd_dir[5:4]    = 2'b01;
    cmd_duty[23:16] = 8'd32;
    req             = 4'b0100;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rst_first_grant", 32'(grant), 32'h4);
    check("rst_first_dir", 32'({dir_r, dir_l}), 32'h1);
    count_pwm(n);
    check("rst_pwm_32", 32'(n), 32'd32);

    tick();
    req = 4'b0000;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/motor_arbiter.md
MOTOR_ARBITER -- requirements
Module: motor_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter PWM_W SHALL default to 8 and sets the duty and PWM counter width.
REQ-003 Parameter DEAD_CYC SHALL default to 16 and sets the dead-time length in clocks.
REQ-004 Parameter STALL_CYC SHALL default to 1024 and sets the stall-detect persistence in clocks.
REQ-005 clk  in  1  system clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 req  in  4  H-bridge requests; bit0 = stall-recovery (highest priority), bit1 = avoid, bit2 = corner, bit3 = search (lowest).
REQ-008 cmd_dir  in  8  per requester {dir_r,dir_l} at [2i+1:2i]; 1 = forward.
REQ-009 cmd_duty  in  4*PWM_W  per requester duty at [PWM_W*(i+1)-1:PWM_W*i].
REQ-010 sense  in  2  motor overcurrent flags {right,left}.
REQ-011 grant  out  4  one-hot grant, or all-zero when no requester is granted.
REQ-012 pwm_l, pwm_r  out  1 each  H-bridge enables.
REQ-013 dir_l, dir_r  out  1 each  H-bridge direction.
REQ-014 stalled  out  1  level, high while the block is in STALL.

Function
REQ-015 The FSM SHALL have the states IDLE, DRIVE, DEAD and STALL.
REQ-016 In IDLE, any req SHALL cause the next clock to grant the highest-priority set bit, load dir_l/dir_r from that requester, and enter DRIVE.
REQ-017 A free-running counter pwm_cnt (PWM_W bits) SHALL wrap from all-ones to 0.
- In DRIVE, pwm_x = (pwm_cnt < duty_x), using the granted requester's live cmd_duty.
- Duty 0 gives pwm constantly low.
- Duty all-ones gives pwm high for 2^PWM_W-1 of every 2^PWM_W clocks.
REQ-018 In DRIVE, the FSM SHALL return to IDLE on the next clock when the granted requester drops req, with grant and pwm low in IDLE.
REQ-019 In DRIVE, the FSM SHALL enter DEAD when either of the following occurs:
- a higher-priority req asserts;
- the granted requester's cmd_dir differs from the latched dir.
REQ-020 Behaviour in DEAD:
- grant SHALL be 0 and pwm_l/pwm_r low; dir SHALL hold its previous value.
- After exactly DEAD_CYC clocks the FSM SHALL re-arbitrate as IDLE does: DRIVE with the new grant, or IDLE if req = 0.
REQ-021 When preemption, a direction change and a holder drop occur in the same clock, the block SHALL take a single DEAD entry, and DEAD SHALL NOT restart while counting.
REQ-022 A req change during DEAD SHALL have no effect until re-arbitration.
REQ-023 Stall detection: if a sense bit is continuously high for STALL_CYC clocks while in DRIVE with nonzero duty on that side, the FSM SHALL enter STALL.
- In STALL: grant = 0, pwm low, stalled = 1.
- The persistence counter SHALL clear whenever both sense bits are 0 or the FSM is outside DRIVE.
REQ-024 STALL exit: when sense = 0 and req[0] = 1, the FSM SHALL go to DEAD and then grant requester 0; when sense = 0 and req = 0, the FSM SHALL go to IDLE; otherwise it SHALL remain in STALL.
REQ-025 Counters SHALL saturate or wrap only as specified in REQ-017, REQ-020 and REQ-023, with no overflow elsewhere.

Reset
REQ-026 While rst_n is low, the following SHALL hold regardless of clk, including mid-DRIVE or mid-DEAD:
- FSM = IDLE;
- grant, pwm_l, pwm_r, dir_l, dir_r and stalled = 0;
- pwm_cnt, the dead counter and the stall counter = 0.
REQ-027 The first grant after reset release SHALL follow REQ-016.

Configuration
REQ-028 When MOTOR_ARB_STALL_EN is defined, REQ-023 and REQ-024 SHALL be implemented.
REQ-029 When MOTOR_ARB_STALL_EN is undefined:
- the STALL state and stall counter SHALL be absent;
- sense SHALL be ignored;
- stalled SHALL be tied to 0.

Structure
REQ-030 Package motor_arb_pkg SHALL hold:
- the FSM state encoding;
- requester index constants REQ_STALL = 0, REQ_AVOID = 1, REQ_CORNER = 2, REQ_SEARCH = 3;
- the default PWM_W, DEAD_CYC and STALL_CYC values.
REQ-031 One sub-module, pwm_gen (counter plus two comparators), SHALL be instantiated once.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- req = 4'b1000, duty3 = 8'd64, dir3 = 2'b11 -> grant = 4'b1000 one clock later; pwm_l high 64 of 256 clocks; dir = 11.
- Holding req3, assert req1 -> grant = 0 and pwm low for exactly 16 clocks, then grant = 4'b0010.
- Holder flips cmd_dir 11 -> 01 -> 16-clock DEAD with grant = 0, then same grant with dir_l = 1, dir_r = 0.
- With MOTOR_ARB_STALL_EN, DRIVE with duty 128 and sense[0] high 1024 clocks -> stalled = 1, pwm low; sense = 0 with req = 4'b0001 -> DEAD, then grant = 4'b0001.
- Drop rst_n during DEAD -> all outputs 0 immediately; after release with req = 4'b0100 -> grant = 4'b0100 one clock later.
- duty = 0 and duty = 8'hFF -> pwm never high, and high 255 of 256 clocks respectively.
